// File: rtl/vram_scanout_if.sv
`default_nettype none
// ============================================================================
// vram_scanout_if : VRAM read port (enable, address, returned data)
// Rev 1.0
// ============================================================================
interface vram_scanout_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 24
) ();
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface
`default_nettype wire

// File: rtl/vram_scanout.sv
`default_nettype none
// ============================================================================
// vram_scanout : raster timing + VRAM reader, RGB/syncs aligned to read data.
// Optional colour-bar generator: VRAM_SCANOUT_TESTPAT_EN.   Rev 1.0
// ============================================================================
module vram_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 24,
    parameter int RD_LAT   = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          en,
`ifdef VRAM_SCANOUT_TESTPAT_EN
    input  wire logic          test_mode,
`endif
    vram_scanout_if.master     vram,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               de,
    output logic [DATA_W-1:0]  pix,
    output logic               frame_start
);
    localparam int c_h_tot = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_tot = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hw    = (c_h_tot > 1) ? $clog2(c_h_tot) : 1;
    localparam int c_vw    = (c_v_tot > 1) ? $clog2(c_v_tot) : 1;

    localparam logic [c_hw-1:0] c_h_act   = c_hw'(H_ACTIVE);
    localparam logic [c_hw-1:0] c_h_act_l = c_hw'(H_ACTIVE - 1);
    localparam logic [c_hw-1:0] c_h_ss    = c_hw'(H_ACTIVE + H_FP);
    localparam logic [c_hw-1:0] c_h_sl    = c_hw'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [c_hw-1:0] c_h_last  = c_hw'(c_h_tot - 1);
    localparam logic [c_hw-1:0] c_h_one   = c_hw'(1);
    localparam logic [c_vw-1:0] c_v_act   = c_vw'(V_ACTIVE);
    localparam logic [c_vw-1:0] c_v_act_l = c_vw'(V_ACTIVE - 1);
    localparam logic [c_vw-1:0] c_v_ss    = c_vw'(V_ACTIVE + V_FP);
    localparam logic [c_vw-1:0] c_v_sl    = c_vw'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [c_vw-1:0] c_v_last  = c_vw'(c_v_tot - 1);
    localparam logic [c_vw-1:0] c_v_one   = c_vw'(1);
    localparam logic [ADDR_W-1:0] c_a_one = ADDR_W'(1);

    // Delay bundle: [0]=de [1]=hsync_n [2]=vsync_n [3]=frame flag (+[6:4] bar colour, [7] test)
`ifdef VRAM_SCANOUT_TESTPAT_EN
    localparam int c_pw = 8;
`else
    localparam int c_pw = 4;
`endif
    localparam logic [c_pw-1:0] c_idle = c_pw'(4'b0110);

    generate
        if ((64'(H_ACTIVE) * 64'(V_ACTIVE)) > (64'd1 << ADDR_W)) begin : g_addr_w_check
            $error("vram_scanout: H_ACTIVE*V_ACTIVE exceeds 2**ADDR_W");
        end
        if (RD_LAT < 1) begin : g_rd_lat_check
            $error("vram_scanout: RD_LAT must be >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

    state_t            r_state;
    logic [c_hw-1:0]   r_h;
    logic [c_vw-1:0]   r_v;
    logic [ADDR_W-1:0] r_addr;
    logic [c_pw-1:0]   r_dly [RD_LAT];

    logic w_scan, w_act, w_hs_n, w_vs_n, w_fs, w_h_wrap, w_v_wrap, w_last_px;
    logic [c_pw-1:0]   w_raw;
    logic [c_pw-1:0]   w_tail;
    logic [DATA_W-1:0] w_pix_src;

    assign w_scan    = (r_state == S_SCAN);
    assign w_act     = w_scan && (r_h < c_h_act) && (r_v < c_v_act);
    assign w_hs_n    = !(w_scan && (r_h >= c_h_ss) && (r_h <= c_h_sl));
    assign w_vs_n    = !(w_scan && (r_v >= c_v_ss) && (r_v <= c_v_sl));
    assign w_fs      = w_scan && (r_h == '0) && (r_v == '0);
    assign w_h_wrap  = (r_h == c_h_last);
    assign w_v_wrap  = (r_v == c_v_last);
    assign w_last_px = (r_h == c_h_act_l) && (r_v == c_v_act_l);
    assign w_tail    = r_dly[RD_LAT-1];

`ifdef VRAM_SCANOUT_TESTPAT_EN
    logic [2:0] w_bar;
    logic [2:0] w_col;
    assign w_bar     = 3'((32'(r_h) * 8) / H_ACTIVE);
    assign w_raw     = {test_mode, ~w_bar, w_fs, w_vs_n, w_hs_n, w_act};
    assign w_col     = w_tail[6:4];
    assign w_pix_src = w_tail[7] ? DATA_W'({{8{w_col[2]}}, {8{w_col[1]}}, {8{w_col[0]}}})
                                 : vram.rd_data;
`else
    assign w_raw     = {w_fs, w_vs_n, w_hs_n, w_act};
    assign w_pix_src = vram.rd_data;
`endif

    assign vram.rd_en   = w_act;
    assign vram.rd_addr = r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_h     <= '0;
            r_v     <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_h    <= '0;
                    r_v    <= '0;
                    r_addr <= '0;
                    if (en) r_state <= S_SCAN;
                end
                S_SCAN: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_h     <= '0;
                        r_v     <= '0;
                        r_addr  <= '0;
                    end else begin
                        if (w_h_wrap) begin
                            r_h <= '0;
                            r_v <= w_v_wrap ? '0 : r_v + c_v_one;
                        end else begin
                            r_h <= r_h + c_h_one;
                        end
                        // Wrapping on the last visible pixel keeps rd_addr within the frame
                        if (w_last_px)  r_addr <= '0;
                        else if (w_act) r_addr <= r_addr + c_a_one;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Raw timing waits RD_LAT clocks for its pixel, then everything registers together
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) r_dly[i] <= c_idle;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            de          <= 1'b0;
            pix         <= '0;
            frame_start <= 1'b0;
        end else begin
            r_dly[0] <= w_raw;
            for (int i = 1; i < RD_LAT; i++) r_dly[i] <= r_dly[i-1];
            de          <= w_tail[0];
            hsync_n     <= w_tail[1];
            vsync_n     <= w_tail[2];
            frame_start <= w_tail[3];
            pix         <= w_tail[0] ? w_pix_src : '0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vram_scanout.sv
`default_nettype none
// ============================================================================
// tb_vram_scanout : directed checks on an 8x6 raster (4x3 visible), RD_LAT=1
// Rev 1.0
// ============================================================================
module tb_vram_scanout;
    localparam int AW = 8;
    localparam int DW = 24;
    localparam int NS = 56;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    logic          hsync_n, vsync_n, de, frame_start;
    logic [DW-1:0] pix;

    vram_scanout_if #(.ADDR_W(AW), .DATA_W(DW)) vif ();

    vram_scanout #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
`ifdef VRAM_SCANOUT_TESTPAT_EN
        .test_mode(1'b0),
`endif
        .vram(vif), .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de),
        .pix(pix), .frame_start(frame_start)
    );

    // VRAM returns its address; garbage when not read, which must never reach pix
    always @(posedge clk) vif.rd_data <= vif.rd_en ? DW'(vif.rd_addr) : 24'hBADBAD;

    int max_addr = 0;
    always @(negedge clk) if (vif.rd_en && int'(vif.rd_addr) > max_addr) max_addr = int'(vif.rd_addr);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_addr(input logic [AW-1:0] a, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (vif.rd_en && vif.rd_addr == a) found = 1'b1;
        end
    endtask

    logic          en_s [NS];
    logic [AW-1:0] ad_s [NS];
    logic          de_s [NS], hs_s [NS], vs_s [NS], fs_s [NS];
    logic [DW-1:0] px_s [NS];

`ifdef VRAM_SCANOUT_TESTPAT_EN
    logic          hs2, vs2, de2, fs2;
    logic [DW-1:0] pix2;
    vram_scanout_if #(.ADDR_W(AW), .DATA_W(DW)) vif2 ();
    vram_scanout #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)
    ) dut_tp (
        .clk(clk), .rst(rst), .en(en), .test_mode(1'b1),
        .vram(vif2), .hsync_n(hs2), .vsync_n(vs2), .de(de2),
        .pix(pix2), .frame_start(fs2)
    );
    always @(posedge clk) vif2.rd_data <= DW'(vif2.rd_addr);
`endif

    initial begin
        bit ok;
        int k;
        int h, v, lc;

        // Reset held with en high: everything idle
        en = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst rd_en", vif.rd_en, 0);
        check_eq("rst rd_addr", vif.rd_addr, 0);
        check_eq("rst hsync_n", hsync_n, 1);
        check_eq("rst vsync_n", vsync_n, 1);
        check_eq("rst de", de, 0);
        check_eq("rst pix", pix, 0);
        check_eq("rst frame_start", frame_start, 0);
        rst = 1'b0;

        // Sample index t == raster position t (h=t%8, v=t/8); pins show position t at t+2
        for (int n = 0; n < NS; n++) begin
            @(negedge clk);
            en_s[n] = vif.rd_en;  ad_s[n] = vif.rd_addr;
            de_s[n] = de;         px_s[n] = pix;
            hs_s[n] = hsync_n;    vs_s[n] = vsync_n;   fs_s[n] = frame_start;
        end

        check_eq("first rd_en", en_s[0], 1);
        check_eq("first rd_addr", ad_s[0], 0);
        check_eq("de before data", {de_s[0], de_s[1]}, 2'b00);
        check_eq("first de", de_s[2], 1);
        check_eq("first pix", px_s[2], 0);
        check_eq("first frame_start", fs_s[2], 1);

        k = 0;
        for (int t = 0; t < 48; t++) begin
            h = t % 8;
            v = t / 8;
            check_eq($sformatf("rd_en t=%0d", t), en_s[t], (h < 4 && v < 3) ? 1 : 0);
            if (en_s[t]) begin
                check_eq($sformatf("rd_addr seq %0d", k), ad_s[t], k);
                k++;
            end
            check_eq($sformatf("de t=%0d", t), de_s[t+2], (h < 4 && v < 3) ? 1 : 0);
            check_eq($sformatf("pix t=%0d", t), px_s[t+2], (h < 4 && v < 3) ? v * 4 + h : 0);
            check_eq($sformatf("hsync_n t=%0d", t), hs_s[t+2], (h == 5 || h == 6) ? 0 : 1);
            check_eq($sformatf("vsync_n t=%0d", t), vs_s[t+2], (v == 4) ? 0 : 1);
            check_eq($sformatf("frame_start t=%0d", t), fs_s[t+2], (t == 0) ? 1 : 0);
        end
        check_eq("reads per frame", k, 12);
        for (int ln = 0; ln < 6; ln++) begin
            lc = 0;
            for (int x = 0; x < 8; x++) lc += int'(de_s[ln * 8 + x + 2]);
            check_eq($sformatf("de per line %0d", ln), lc, (ln < 3) ? 4 : 0);
        end
        check_eq("next frame rd_addr", {en_s[48], ad_s[48]}, {1'b1, 8'd0});

        // en dropped right after address 5 is issued
        wait_addr(8'd5, ok);
        check_eq("reach addr 5", ok, 1);
        en = 1'b0;
        @(negedge clk);
        check_eq("drop no rd_en", vif.rd_en, 0);
        @(negedge clk);
        check_eq("drop pending de", de, 1);
        check_eq("drop pending pix", pix, 5);
        lc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lc += int'(vif.rd_en) + int'(de) + int'(!hsync_n) + int'(!vsync_n);
        end
        check_eq("idle after drop", lc, 0);
        en = 1'b1;
        @(negedge clk);
        check_eq("restart rd_en", vif.rd_en, 1);
        check_eq("restart rd_addr", vif.rd_addr, 0);

        // One-clock reset at v=1,h=2 (address 6)
        wait_addr(8'd6, ok);
        check_eq("reach addr 6", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst rd_en", vif.rd_en, 0);
        check_eq("midrst rd_addr", vif.rd_addr, 0);
        check_eq("midrst de", de, 0);
        check_eq("midrst pix", pix, 0);
        check_eq("midrst syncs", {hsync_n, vsync_n, frame_start}, 3'b110);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post-rst rd_en", vif.rd_en, 1);
        check_eq("post-rst rd_addr", vif.rd_addr, 0);
        repeat (2) @(negedge clk);
        check_eq("post-rst frame_start", {de, frame_start}, 2'b11);
        check_eq("post-rst pix", pix, 0);
        repeat (60) @(negedge clk);
        check_eq("max rd_addr", max_addr, 11);

`ifdef VRAM_SCANOUT_TESTPAT_EN
        begin
            logic [DW-1:0] bars [8];
            bars = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
                     24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};
            ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                if (fs2) ok = 1'b1;
            end
            check_eq("testpat frame_start", ok, 1);
            for (int c = 0; c < 8; c++) begin
                check_eq($sformatf("testpat col %0d", c), pix2, bars[c]);
                @(negedge clk);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
